// File: rtl/regfile_mp_sb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb_pkg
//   Shared constants for the parametrised integer register file. Decode and
//   writeback share these so that the data width and the hardwired-zero
//   register number live in one place.
//   Contents:
//     XLEN_DEF  default data width of each register
//     REG_ZERO  architectural register number of the hardwired zero register
//     NRD_MAX   largest supported number of read ports
// ---------------------------------------------------------------------------
package regfile_mp_sb_pkg;

  localparam int         XLEN_DEF = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         NRD_MAX  = 4;

endpackage : regfile_mp_sb_pkg

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   Per-register pending-write bits. Issue reserves a destination, writeback
//   releases it. Bit 0 is constant zero and has no flop.
//   Ports:
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset, clears every bit
//     wr_en     writeback strobe (release)
//     wr_addr   register being released
//     rsv_en    issue-stage reservation strobe
//     rsv_addr  register being reserved
//     sb        current pending bit of every register
//     any_busy  registered OR of all pending bits
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_mp_sb_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic [NREGS-1:0] sb,
  output logic             any_busy
);

  logic [NREGS-1:0] sb_next;

  assign sb[0]      = 1'b0;
  assign sb_next[0] = 1'b0;

  for (genvar i = 1; i < NREGS; i++) begin : g_bit
    logic set_bit;
    logic clr_bit;
    logic q;

    assign set_bit = rsv_en && (rsv_addr == AW'(i));
    assign clr_bit = wr_en  && (wr_addr  == AW'(i));

    // A reservation and a release hitting the same register on one edge
    // leave the bit set: the reservation belongs to a newer producer than
    // the value being written back.
    assign sb_next[i] = set_bit | (q & ~clr_bit);

    // Pending bit flop for register i.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= 1'b0;
      end else begin
        q <= sb_next[i];
      end
    end

    assign sb[i] = q;
  end

  // any_busy is registered from the next-state vector so it changes on the
  // same edge as the scoreboard bits themselves, not one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_busy <= 1'b0;
    end else begin
      any_busy <= |sb_next[NREGS-1:1];
    end
  end

endmodule : regfile_scoreboard

// File: rtl/regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb
//   Parametrised integer register file with NRD combinational read ports,
//   one write port, optional write-to-read bypass and a pending-write
//   scoreboard for RAW hazard detection at decode. Register 0 reads as zero
//   and is never busy.
//   Ports:
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset
//     rd_addr   read addresses, port k at [k*AW +: AW]
//     rd_data   read data, port k at [k*XLEN +: XLEN]
//     rd_busy   port k's register has a pending write
//     wr_en     writeback write strobe
//     wr_addr   writeback destination
//     wr_data   writeback value
//     rsv_en    issue-stage reservation strobe
//     rsv_addr  destination being reserved
//     any_busy  OR of all scoreboard bits (pipeline drain indicator)
// ---------------------------------------------------------------------------
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  output logic              any_busy
);

  // Reject inconsistent geometry at elaboration time.
  if ((NREGS < 2) || (AW != $clog2(NREGS)) || ((1 << AW) != NREGS)) begin : g_bad_geom
    $error("regfile_mp_sb: NREGS must be a power of two >= 2 and AW must equal clog2(NREGS)");
  end
  if ((NRD < 1) || (NRD > NRD_MAX)) begin : g_bad_nrd
    $error("regfile_mp_sb: NRD must be between 1 and 4");
  end

  localparam bit BYP = (BYPASS != 0);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] sb;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .sb       (sb),
    .any_busy (any_busy)
  );

  assign mem[0] = '0;

  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    logic [XLEN-1:0] q;

    // Data flop for register i; writes to register 0 never match here.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (wr_en && (wr_addr == AW'(i))) begin
        q <= wr_data;
      end
    end

    assign mem[i] = q;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          is_zero;
    logic          byp_hit;
    logic          rsv_hit;

    assign addr    = rd_addr[k*AW +: AW];
    assign is_zero = (addr == '0);
    // Bypass is suppressed while reset is held so a strobe driven during
    // reset cannot leak onto the read data.
    assign byp_hit = BYP && rst_n && wr_en && !is_zero && (wr_addr == addr);
    assign rsv_hit = rsv_en && (rsv_addr == addr);

    // A bypassed value is by definition released, unless a newer producer
    // is reserving the same register in this very cycle.
    always_comb begin
      rd_data[k*XLEN +: XLEN] = mem[addr];
      rd_busy[k]              = sb[addr];
      if (is_zero) begin
        rd_data[k*XLEN +: XLEN] = '0;
        rd_busy[k]              = 1'b0;
      end else if (byp_hit) begin
        rd_data[k*XLEN +: XLEN] = wr_data;
        rd_busy[k]              = rsv_hit;
      end
    end
  end

endmodule : regfile_mp_sb
